// File: rtl/abc_coinc_gated.sv
// rtl/abc_coinc_gated.sv - gated two-channel coincidence counter with saturating counts
module abc_coinc_gated #(
   parameter int CNT_W  = 16,
   parameter int WIN_W  = 4,
   parameter int GATE_W = 24
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              x1,
   input  logic              x2,
   input  logic              start,
   input  logic [GATE_W-1:0] gate_len,
   input  logic [WIN_W-1:0]  win_len,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  count_a,
   output logic [CNT_W-1:0]  count_b,
   output logic [CNT_W-1:0]  count_c,
   output logic              ovf
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
   typedef enum logic [1:0] {P_NONE, P_X1, P_X2} pend_t;

   localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);
   localparam logic [WIN_W-1:0]  WIN_ONE  = WIN_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   state_t            state, state_nx;
   pend_t             pend, pend_nx;
   logic [WIN_W-1:0]  wtmr, wtmr_nx, win_r;
   logic [GATE_W-1:0] gate_tmr;
   logic [CNT_W-1:0]  live_a, live_b, live_c;
   logic              live_ovf;
   logic [2:0]        sync1, sync2;
   logic              e1, e2;
   logic              inc_a, inc_b, inc_c, sat_hit;
   logic              accept, classify;

   // bits [1:0] are the synchroniser, bit [2] is the previous level for edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {sync1[1:0], x1};
         sync2 <= {sync2[1:0], x2};
      end
   end

   assign e1       = sync1[1] & ~sync1[2];
   assign e2       = sync2[1] & ~sync2[2];
   assign accept   = (state == IDLE) && start;
   assign classify = (state == RUN) && enable;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = (gate_len == '0) ? FLUSH : RUN;
         RUN:     if (enable && gate_tmr == GATE_ONE) state_nx = FLUSH;
         FLUSH:   state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // a pending event waits win_r enabled cycles for its partner before it counts as a single
   always_comb begin
      inc_a   = 1'b0;
      inc_b   = 1'b0;
      inc_c   = 1'b0;
      pend_nx = pend;
      wtmr_nx = wtmr;
      if (classify) begin
         case (pend)
            P_NONE: begin
               if (e1 && e2) begin
                  inc_c = 1'b1;
               end else if (e1) begin
                  if (win_r == '0) inc_b = 1'b1;
                  else begin pend_nx = P_X1; wtmr_nx = win_r; end
               end else if (e2) begin
                  if (win_r == '0) inc_a = 1'b1;
                  else begin pend_nx = P_X2; wtmr_nx = win_r; end
               end
            end
            P_X1: begin
               if (e2) begin
                  inc_c   = 1'b1;
                  pend_nx = e1 ? P_X1 : P_NONE;
                  wtmr_nx = win_r;
               end else if (e1) begin
                  inc_b   = 1'b1;
                  wtmr_nx = win_r;
               end else if (wtmr == WIN_ONE) begin
                  inc_b   = 1'b1;
                  pend_nx = P_NONE;
               end else begin
                  wtmr_nx = wtmr - WIN_ONE;
               end
            end
            P_X2: begin
               if (e1) begin
                  inc_c   = 1'b1;
                  pend_nx = e2 ? P_X2 : P_NONE;
                  wtmr_nx = win_r;
               end else if (e2) begin
                  inc_a   = 1'b1;
                  wtmr_nx = win_r;
               end else if (wtmr == WIN_ONE) begin
                  inc_a   = 1'b1;
                  pend_nx = P_NONE;
               end else begin
                  wtmr_nx = wtmr - WIN_ONE;
               end
            end
            default: pend_nx = P_NONE;
         endcase
      end else if (state == FLUSH) begin
         inc_b   = (pend == P_X1);
         inc_a   = (pend == P_X2);
         pend_nx = P_NONE;
      end
   end

   assign sat_hit = (inc_a & (&live_a)) | (inc_b & (&live_b)) | (inc_c & (&live_c));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend     <= P_NONE;
         wtmr     <= '0;
         win_r    <= '0;
         gate_tmr <= '0;
         live_a   <= '0;
         live_b   <= '0;
         live_c   <= '0;
         live_ovf <= 1'b0;
         count_a  <= '0;
         count_b  <= '0;
         count_c  <= '0;
         ovf      <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done     <= (state == DONE);
         pend     <= pend_nx;
         wtmr     <= wtmr_nx;
         live_ovf <= live_ovf | sat_hit;
         if (inc_a && !(&live_a)) live_a <= live_a + CNT_ONE;
         if (inc_b && !(&live_b)) live_b <= live_b + CNT_ONE;
         if (inc_c && !(&live_c)) live_c <= live_c + CNT_ONE;
         if (classify) gate_tmr <= gate_tmr - GATE_ONE;
         if (accept) begin
            live_a   <= '0;
            live_b   <= '0;
            live_c   <= '0;
            live_ovf <= 1'b0;
            gate_tmr <= gate_len;
            win_r    <= win_len;
            pend     <= P_NONE;
            wtmr     <= '0;
            busy     <= 1'b1;
         end
         if (state == DONE) begin
            count_a <= live_a;
            count_b <= live_b;
            count_c <= live_c;
            ovf     <= live_ovf;
            busy    <= 1'b0;
         end
      end
   end

endmodule

// File: doc/abc_coinc_gated.md
Name: abc_coinc_gated

Overview:
Gated two-channel coincidence counter, parametrised successor of the fixed 4-bit X1/X2 coincidence counters. It synchronises two asynchronous detector inputs and edge-detects them. Edges are classified as X2-only (A), X1-only (B) or coincident (C) within a programmable window, over a programmable gate period. Counters are saturating with a sticky overflow flag, and results are latched with a done pulse for the readout logic.

Parameters:
CNT_W, 16, width of each event counter and result output
WIN_W, 4, width of coincidence window length input
GATE_W, 24, width of gate length input

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  run qualifier; low freezes gate timer, window timer and ignores edges
x1  input  1  detector channel 1, asynchronous level
x2  input  1  detector channel 2, asynchronous level
start  input  1  begin acquisition; sampled only in IDLE
gate_len  input  GATE_W  number of enabled cycles in RUN; sampled on accepted start
win_len  input  WIN_W  coincidence window in cycles; sampled on accepted start
busy  output  1  high from cycle after accepted start until done cycle
done  output  1  one-cycle pulse, results valid
count_a  output  CNT_W  X2-only events of last completed gate
count_b  output  CNT_W  X1-only events of last completed gate
count_c  output  CNT_W  coincident events of last completed gate
ovf  output  1  any counter saturated during last gate

Behaviour:
- Reset (async, any state): FSM to IDLE; busy, done, ovf = 0; count_a/b/c = 0; live counters, timers and pending flags cleared; synchroniser flops cleared.
- Input path: 2-flop synchroniser per channel, then rising-edge detect producing e1/e2. The path runs in all states. A level already high at start is not an edge. Pin-to-edge-pulse latency is 3 cycles.
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE: start=1 clears live counters and live overflow, loads gate timer with gate_len, captures win_len, and goes to RUN. busy=1 from the next cycle. If gate_len=0, go straight to FLUSH.
- RUN: each enabled cycle decrements the gate timer. Classification (below) is applied only in enabled cycles. When the timer goes 1->0, go to FLUSH.
- FLUSH (1 cycle): an open pending event is counted as a single (pend1 -> B, pend2 -> A). Edges are ignored. Go to DONE.
- DONE (1 cycle): count_a/b/c and ovf are loaded from live values; done=1 and busy=0 this cycle. Go to IDLE. start is ignored in RUN, FLUSH and DONE.
- Classification state: none / pend1 (X1 waiting) / pend2 (X2 waiting), plus a window timer.
  - none: e1&e2 -> C+1. e1 only -> pend1 with timer=win. e2 only -> pend2 with timer=win.
  - win=0: no pending is ever opened; a lone edge counts its single immediately.
  - pend1 with e2 -> C+1, pending consumed. A simultaneous e1 opens a fresh pend1.
  - pend1 with e1 only -> B+1 for the old event, fresh pend1 with timer=win.
  - pend1 with no edge: if timer=1, B+1 and go to none; else timer-1. pend2 is symmetric (A for X2).
  - Net effect: a partner edge in any of the win enabled cycles after the opening cycle coincides.
- Each counter increments at most once per cycle. At all-ones it holds, and the live overflow is set (sticky until next start).
- Results hold until the next DONE; a new start does not clear the outputs.
- Reset mid-RUN: acquisition is discarded and the outputs are zero.

Test Plan:
- gate_len=100, win_len=0, one x1-only pulse, one x2-only pulse, one simultaneous pulse on both -> done at start+102, A=1, B=1, C=1, ovf=0.
- win_len=3: x1 edge, then x2 edge 3 cycles later -> C=1; repeat with a gap of 4 -> A=1, B=1, C=0.
- CNT_W=4, win_len=0, 20 simultaneous pulses -> C=15, ovf=1; next run with no pulses -> C=0, ovf=0.
- gate_len=10, enable toggled 50% duty -> busy lasts about 20 RUN cycles; x1 pulses during enable=0 are not counted.
- x1 edge 1 cycle before the gate ends, win_len=5 -> FLUSH counts B=1; start pulsed while busy -> ignored, single done pulse.
- reset asserted mid-RUN after 3 counted coincidences -> outputs 0, busy=0; next start runs normally; x1 held high across start -> no count.
